// File: rtl/sphere_scan_scheduler_if.sv
// Signal bundle between the sphere scan scheduler and its environment:
// table load, ray request, result return and the detector handshake.
interface sphere_scan_scheduler_if #(
  parameter int NUM_SPHERES = 8,
  parameter int IDX_W       = $clog2(NUM_SPHERES)
);
  logic             TblWrEn;
  logic [IDX_W-1:0] TblWrAddr;
  logic [31:0]      TblWrX, TblWrY, TblWrZ, TblWrR;
  logic             TblClear;

  logic             RayValid, RayReady;
  logic [31:0]      RayStartX, RayStartY, RayStartZ, RayDirX, RayDirY, RayDirZ;

  logic             ResultValid, ResultReady, ResultHit, ResultTimeout;
  logic [IDX_W-1:0] ResultIndex;
  logic [31:0]      ResultDistance;

  logic [31:0]      DetSphereX, DetSphereY, DetSphereZ, DetSphereRadius;
  logic [31:0]      DetRayStartX, DetRayStartY, DetRayStartZ;
  logic [31:0]      DetRayDirX, DetRayDirY, DetRayDirZ;
  logic             DetInputValid, DetInputReady, DetOutputReady, DetIntersects;
  logic [31:0]      DetDistance;

  modport slave (
    input  TblWrEn, TblWrAddr, TblWrX, TblWrY, TblWrZ, TblWrR, TblClear,
    input  RayValid, RayStartX, RayStartY, RayStartZ, RayDirX, RayDirY, RayDirZ,
    output RayReady,
    output ResultValid, ResultHit, ResultIndex, ResultDistance, ResultTimeout,
    input  ResultReady,
    output DetSphereX, DetSphereY, DetSphereZ, DetSphereRadius,
    output DetRayStartX, DetRayStartY, DetRayStartZ, DetRayDirX, DetRayDirY, DetRayDirZ,
    output DetInputValid,
    input  DetInputReady, DetOutputReady, DetIntersects, DetDistance
  );

  modport master (
    output TblWrEn, TblWrAddr, TblWrX, TblWrY, TblWrZ, TblWrR, TblClear,
    output RayValid, RayStartX, RayStartY, RayStartZ, RayDirX, RayDirY, RayDirZ,
    input  RayReady,
    input  ResultValid, ResultHit, ResultIndex, ResultDistance, ResultTimeout,
    output ResultReady,
    input  DetSphereX, DetSphereY, DetSphereZ, DetSphereRadius,
    input  DetRayStartX, DetRayStartY, DetRayStartZ, DetRayDirX, DetRayDirY, DetRayDirZ,
    input  DetInputValid,
    output DetInputReady, DetOutputReady, DetIntersects, DetDistance
  );
endinterface

// File: rtl/sphere_scan_scheduler.sv
// Walks the sphere table for one ray, feeds each valid entry to the detector
// and reduces the returned distances to the nearest hit.
module sphere_scan_scheduler #(
  parameter int NUM_SPHERES = 8,
  parameter int IDX_W       = $clog2(NUM_SPHERES),
  parameter int TIMEOUT     = 64
) (
  input  logic                   CLK,
  input  logic                   areset,
  sphere_scan_scheduler_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef struct packed { logic [31:0] x, y, z, r; } sph_t;
  typedef struct packed { logic [31:0] sx, sy, sz, dx, dy, dz; } ray_t;

  state_t                  r_state, w_next;
  sph_t [NUM_SPHERES-1:0]  r_tbl;
  logic [NUM_SPHERES-1:0]  r_tbl_vld;
  ray_t                    r_ray, r_det_ray;
  sph_t                    r_det_sph;
  logic [IDX_W:0]          r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_best_hit, r_timeout;
  logic [IDX_W-1:0]        r_best_idx;
  logic [31:0]             r_best_dist;

  logic w_accept, w_load, w_skip, w_hs, w_strobe, w_to;
  logic w_ray_ready, w_res_valid, w_det_valid;
  logic w_cnt_last;
  logic [IDX_W-1:0] w_idx_lo;

  // Index is one bit wider than the table so the top bit flags end of scan.
  assign w_idx_lo   = r_idx[IDX_W-1:0];
  assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_accept    = 1'b0;
    w_load      = 1'b0;
    w_skip      = 1'b0;
    w_hs        = 1'b0;
    w_strobe    = 1'b0;
    w_to        = 1'b0;
    w_ray_ready = 1'b0;
    w_res_valid = 1'b0;
    w_det_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ray_ready = 1'b1;
        if (bus.RayValid) begin
          w_accept = 1'b1;
          w_next   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (r_idx[IDX_W])             w_next = S_DONE;
        else if (r_tbl_vld[w_idx_lo]) begin
          w_load = 1'b1;
          w_next = S_ISSUE;
        end else                      w_skip = 1'b1;
      end
      S_ISSUE: begin
        w_det_valid = 1'b1;
        if (bus.DetInputReady) begin
          w_hs   = 1'b1;
          w_next = S_WAIT;
        end else if (w_cnt_last) begin
          w_to   = 1'b1;
          w_next = S_DONE;
        end
      end
      S_WAIT: begin
        if (bus.DetOutputReady) begin
          w_strobe = 1'b1;
          w_next   = S_SCAN;
        end else if (w_cnt_last) begin
          w_to   = 1'b1;
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_res_valid = 1'b1;
        if (bus.ResultReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Table payload carries no reset; only the valid bits need clearing.
  always_ff @(posedge CLK) begin
    if (r_state == S_IDLE && bus.TblWrEn)
      r_tbl[bus.TblWrAddr] <= '{bus.TblWrX, bus.TblWrY, bus.TblWrZ, bus.TblWrR};
  end

  always_ff @(posedge CLK or negedge areset) begin
    if (!areset) begin
      r_tbl_vld   <= '0;
      r_ray       <= '0;
      r_det_ray   <= '0;
      r_det_sph   <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_best_hit  <= 1'b0;
      r_best_idx  <= '0;
      r_best_dist <= '1;
      r_timeout   <= 1'b0;
    end else begin
      // Clear first so a same-cycle write leaves its entry valid.
      if (r_state == S_IDLE) begin
        if (bus.TblClear) r_tbl_vld <= '0;
        if (bus.TblWrEn)  r_tbl_vld[bus.TblWrAddr] <= 1'b1;
      end
      if (w_accept) begin
        r_ray       <= '{bus.RayStartX, bus.RayStartY, bus.RayStartZ,
                         bus.RayDirX, bus.RayDirY, bus.RayDirZ};
        r_idx       <= '0;
        r_best_hit  <= 1'b0;
        r_best_idx  <= '0;
        r_best_dist <= '1;
        r_timeout   <= 1'b0;
      end
      if (w_skip) r_idx <= r_idx + 1'b1;
      if (w_load) begin
        r_det_sph <= r_tbl[w_idx_lo];
        r_det_ray <= r_ray;
      end
      if (w_load || w_hs)                            r_cnt <= '0;
      else if (r_state == S_ISSUE || r_state == S_WAIT) r_cnt <= r_cnt + 1'b1;
      // Strict compare keeps the lower index on equal distances.
      if (w_strobe) begin
        if (bus.DetIntersects && (bus.DetDistance < r_best_dist)) begin
          r_best_hit  <= 1'b1;
          r_best_idx  <= w_idx_lo;
          r_best_dist <= bus.DetDistance;
        end
        r_idx <= r_idx + 1'b1;
      end
      if (w_to) r_timeout <= 1'b1;
    end
  end

  assign bus.RayReady        = w_ray_ready;
  assign bus.ResultValid     = w_res_valid;
  assign bus.ResultHit       = r_best_hit;
  assign bus.ResultIndex     = r_best_idx;
  assign bus.ResultDistance  = r_best_dist;
  assign bus.ResultTimeout   = r_timeout;
  assign bus.DetInputValid   = w_det_valid;
  assign bus.DetSphereX      = r_det_sph.x;
  assign bus.DetSphereY      = r_det_sph.y;
  assign bus.DetSphereZ      = r_det_sph.z;
  assign bus.DetSphereRadius = r_det_sph.r;
  assign bus.DetRayStartX    = r_det_ray.sx;
  assign bus.DetRayStartY    = r_det_ray.sy;
  assign bus.DetRayStartZ    = r_det_ray.sz;
  assign bus.DetRayDirX      = r_det_ray.dx;
  assign bus.DetRayDirY      = r_det_ray.dy;
  assign bus.DetRayDirZ      = r_det_ray.dz;
endmodule

// File: tb/tb_sphere_scan_scheduler.sv
// Directed bench for sphere_scan_scheduler with a simple fixed-latency
// detector model whose per-entry answers are set by each test.
module tb_sphere_scan_scheduler;
  localparam int NS = 8;
  localparam int IW = 3;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  sphere_scan_scheduler_if #(.NUM_SPHERES(NS)) bus();
  sphere_scan_scheduler #(.NUM_SPHERES(NS), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .CLK(clk), .areset(areset), .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic [31:0] tx[NS], ty[NS], tz[NS], tr[NS];
  logic        rhit[NS];
  logic [31:0] rdist[NS];
  logic [31:0] ray[6];
  bit          never = 1'b0;
  bit          stray = 1'b0;
  int          n_hs = 0;
  int          pend = 0;
  int          cur = 0;
  int          k = 0;

  // Detector: ready always, strobe 2 edges after the handshake edge.
  // Between strobes the hit/distance lines carry a tempting value (hit at 1).
  initial begin : det_model
    bus.DetInputReady  = 1'b1;
    bus.DetOutputReady = 1'b0;
    bus.DetIntersects  = 1'b1;
    bus.DetDistance    = 32'd1;
    forever begin
      @(negedge clk);
      bus.DetOutputReady = stray;
      bus.DetIntersects  = 1'b1;
      bus.DetDistance    = stray ? 32'd3 : 32'd1;
      if (pend > 0) begin
        pend--;
        if (pend == 0 && !never) begin
          bus.DetOutputReady = 1'b1;
          bus.DetIntersects  = rhit[cur];
          bus.DetDistance    = rdist[cur];
        end
      end
      if (bus.DetInputValid && bus.DetInputReady && areset) begin
        n_hs++;
        cur = -1;
        for (int i = 0; i < NS; i++) if (tx[i] == bus.DetSphereX) cur = i;
        chk("op_find", 32'(cur >= 0), 32'd1);
        if (cur < 0) cur = 0;
        chk("op_y",  bus.DetSphereY,      ty[cur]);
        chk("op_z",  bus.DetSphereZ,      tz[cur]);
        chk("op_r",  bus.DetSphereRadius, tr[cur]);
        chk("op_sx", bus.DetRayStartX,    ray[0]);
        chk("op_sz", bus.DetRayStartZ,    ray[2]);
        chk("op_dy", bus.DetRayDirY,      ray[4]);
        pend = 2;
      end
    end
  end

  task automatic wr(input int i, input bit clr);
    bus.TblWrEn   = 1'b1;
    bus.TblWrAddr = IW'(i);
    bus.TblWrX    = tx[i];
    bus.TblWrY    = ty[i];
    bus.TblWrZ    = tz[i];
    bus.TblWrR    = tr[i];
    bus.TblClear  = clr;
    @(negedge clk);
    bus.TblWrEn   = 1'b0;
    bus.TblClear  = 1'b0;
  endtask

  task automatic clr_tbl();
    bus.TblClear = 1'b1;
    @(negedge clk);
    bus.TblClear = 1'b0;
  endtask

  task automatic start_ray(input logic [31:0] seed);
    for (int j = 0; j < 6; j++) ray[j] = seed + 32'(j);
    bus.RayStartX = ray[0];
    bus.RayStartY = ray[1];
    bus.RayStartZ = ray[2];
    bus.RayDirX   = ray[3];
    bus.RayDirY   = ray[4];
    bus.RayDirZ   = ray[5];
    bus.RayValid  = 1'b1;
    @(negedge clk);
    bus.RayValid  = 1'b0;
  endtask

  // k = edges after the accept edge until ResultValid is seen.
  task automatic run_ray(input logic [31:0] seed, output int lat);
    start_ray(seed);
    chk("ray_ready_low", bus.RayReady, 1'b0);
    lat = 0;
    while (!bus.ResultValid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 300) chk("result_bound", 32'(lat), 32'd0);
  endtask

  task automatic res(input string t, input logic h, input logic [31:0] i,
                     input logic [31:0] d, input logic to);
    chk({t, ".valid"}, bus.ResultValid,    1'b1);
    chk({t, ".hit"},   bus.ResultHit,      h);
    chk({t, ".idx"},   bus.ResultIndex,    i);
    chk({t, ".dist"},  bus.ResultDistance, d);
    chk({t, ".to"},    bus.ResultTimeout,  to);
  endtask

  task automatic take();
    bus.ResultReady = 1'b1;
    @(negedge clk);
    bus.ResultReady = 1'b0;
    chk("taken.rdy", bus.RayReady,    1'b1);
    chk("taken.rv",  bus.ResultValid, 1'b0);
  endtask

  initial begin : main
    for (int i = 0; i < NS; i++) begin
      tx[i] = 32'h100 + 32'(i);
      ty[i] = 32'h200 + 32'(i * 7);
      tz[i] = 32'h300 + 32'(i * 13);
      tr[i] = 32'h40 + 32'(i);
      rhit[i]  = 1'b0;
      rdist[i] = 32'hDEAD;
    end
    bus.TblWrEn = 1'b0; bus.TblWrAddr = '0; bus.TblClear = 1'b0;
    bus.TblWrX = '0; bus.TblWrY = '0; bus.TblWrZ = '0; bus.TblWrR = '0;
    bus.RayValid = 1'b0; bus.ResultReady = 1'b0;
    bus.RayStartX = '0; bus.RayStartY = '0; bus.RayStartZ = '0;
    bus.RayDirX = '0; bus.RayDirY = '0; bus.RayDirZ = '0;

    repeat (2) @(negedge clk);
    chk("rst.rdy",  bus.RayReady,       1'b1);
    chk("rst.rv",   bus.ResultValid,    1'b0);
    chk("rst.hit",  bus.ResultHit,      1'b0);
    chk("rst.idx",  bus.ResultIndex,    '0);
    chk("rst.dist", bus.ResultDistance, 32'hFFFFFFFF);
    chk("rst.to",   bus.ResultTimeout,  1'b0);
    chk("rst.div",  bus.DetInputValid,  1'b0);
    chk("rst.dsx",  bus.DetSphereX,     '0);
    chk("rst.drdz", bus.DetRayDirZ,     '0);
    areset = 1'b1;
    @(negedge clk);

    // Empty table
    clr_tbl();
    n_hs = 0;
    run_ray(32'hA0, k);
    chk("t1.lat", 32'(k), 32'd9);
    res("t1", 1'b0, 0, 32'hFFFFFFFF, 1'b0);
    chk("t1.hs", 32'(n_hs), 32'd0);
    take();

    // Entries 1,4,6: distances 100,40,40 -> lowest index of the tie wins
    rhit[1] = 1'b1; rdist[1] = 32'd100;
    rhit[4] = 1'b1; rdist[4] = 32'd40;
    rhit[6] = 1'b1; rdist[6] = 32'd40;
    wr(1, 1'b1);
    wr(4, 1'b0);
    wr(6, 1'b0);
    n_hs = 0;
    run_ray(32'hB0, k);
    chk("t2.lat", 32'(k), 32'd18);
    res("t2", 1'b1, 4, 32'd40, 1'b0);
    chk("t2.hs", 32'(n_hs), 32'd3);
    take();

    // Entry 2 only, detector reports a miss
    rdist[2] = 32'd5;
    wr(2, 1'b1);
    n_hs = 0;
    run_ray(32'hC0, k);
    chk("t3.lat", 32'(k), 32'd12);
    res("t3", 1'b0, 0, 32'hFFFFFFFF, 1'b0);
    chk("t3.hs", 32'(n_hs), 32'd1);

    // Consumer stalls; a table write during DONE must be dropped
    rhit[3] = 1'b1; rdist[3] = 32'd7;
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        bus.TblWrEn = 1'b1; bus.TblWrAddr = 3'd3;
        bus.TblWrX = tx[3]; bus.TblWrY = ty[3]; bus.TblWrZ = tz[3]; bus.TblWrR = tr[3];
      end
      @(negedge clk);
      bus.TblWrEn = 1'b0;
      chk("hold.rv",   bus.ResultValid,    1'b1);
      chk("hold.rdy",  bus.RayReady,       1'b0);
      chk("hold.dist", bus.ResultDistance, 32'hFFFFFFFF);
      chk("hold.hit",  bus.ResultHit,      1'b0);
    end
    take();
    n_hs = 0;
    run_ray(32'hD0, k);
    chk("t3b.lat", 32'(k), 32'd12);
    res("t3b", 1'b0, 0, 32'hFFFFFFFF, 1'b0);
    chk("t3b.hs", 32'(n_hs), 32'd1);
    take();

    // Entry 0, detector never answers -> timeout after 64 WAIT cycles
    rhit[0] = 1'b1; rdist[0] = 32'd9;
    wr(0, 1'b1);
    never = 1'b1;
    run_ray(32'hE0, k);
    chk("t4.lat", 32'(k), 32'd66);
    res("t4", 1'b0, 0, 32'hFFFFFFFF, 1'b1);
    take();
    @(posedge clk); #2 stray = 1'b1;
    @(posedge clk); #2 stray = 1'b0;
    @(negedge clk);
    chk("stray.rdy",  bus.RayReady,       1'b1);
    chk("stray.rv",   bus.ResultValid,    1'b0);
    chk("stray.hit",  bus.ResultHit,      1'b0);
    chk("stray.dist", bus.ResultDistance, 32'hFFFFFFFF);

    // Reset while waiting on the detector
    start_ray(32'hF0);
    repeat (4) @(negedge clk);
    chk("t5.inwait", bus.DetSphereX, tx[0]);
    #2 areset = 1'b0;
    #1;
    chk("t5.rdy",  bus.RayReady,       1'b1);
    chk("t5.rv",   bus.ResultValid,    1'b0);
    chk("t5.div",  bus.DetInputValid,  1'b0);
    chk("t5.dsx",  bus.DetSphereX,     '0);
    chk("t5.dsy",  bus.DetRayStartX,   '0);
    chk("t5.dist", bus.ResultDistance, 32'hFFFFFFFF);
    chk("t5.to",   bus.ResultTimeout,  1'b0);
    @(negedge clk);
    areset = 1'b1;
    never  = 1'b0;
    @(negedge clk);
    n_hs = 0;
    run_ray(32'h110, k);
    chk("t5b.lat", 32'(k), 32'd9);
    res("t5b", 1'b0, 0, 32'hFFFFFFFF, 1'b0);
    chk("t5b.hs", 32'(n_hs), 32'd0);
    take();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/sphere_scan_scheduler.md
# sphere_scan_scheduler

Sequencer that sits in front of one sphere-intersection detector. It holds a small sphere table and accepts one ray at a time. It issues every valid table entry to the detector over the detector's InputValid/InputReady/OutputReady handshake and reduces the results to the nearest hit. It returns one result record per ray: hit flag, sphere index, distance and timeout flag.

## Interface
Parameters:
- NUM_SPHERES, 8: table depth; power of two, at least 2.
- IDX_W, $clog2(NUM_SPHERES): index width.
- TIMEOUT, 64: maximum cycles spent in ISSUE or WAIT for one sphere.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-low reset.
- TblWrEn  in  1  write table entry; honoured only in IDLE.
- TblWrAddr  in  IDX_W  entry written.
- TblWrX, TblWrY, TblWrZ, TblWrR  in  32 each  sphere centre and radius.
- TblClear  in  1  clears all entry valid bits; honoured only in IDLE.
- RayValid  in  1  ray offered.
- RayReady  out  1  high exactly in IDLE.
- RayStartX/Y/Z, RayDirX/Y/Z  in  32 each  ray; sampled on accept.
- ResultValid  out  1  result held until taken.
- ResultReady  in  1  result consumer ready.
- ResultHit  out  1  at least one entry intersected.
- ResultIndex  out  IDX_W  nearest hit entry; 0 if no hit.
- ResultDistance  out  32  nearest hit distance; 32'hFFFFFFFF if no hit.
- ResultTimeout  out  1  scan aborted by timeout.
- DetSphereX/Y/Z/Radius, DetRayStartX/Y/Z, DetRayDirX/Y/Z  out  32 each  detector operands; registered.
- DetInputValid  out  1  request to detector.
- DetInputReady  in  1  detector idle.
- DetOutputReady  in  1  one-cycle result strobe.
- DetIntersects  in  1  detector hit flag.
- DetDistance  in  32  detector distance; unsigned.

## Operation
- States are IDLE, SCAN, ISSUE, WAIT and DONE. The index register is IDX_W+1 bits wide.
- IDLE:
  - RayValid high: latch the ray, set idx=0, bestHit=0, bestIdx=0, bestDist=32'hFFFFFFFF, timeout=0. Next state is SCAN.
  - Table writes and clears are applied in IDLE. TblClear and TblWrEn in the same cycle: the written entry ends valid.
  - A write in the same cycle as a ray accept is visible to that scan.
- SCAN:
  - idx==NUM_SPHERES: go to DONE.
  - Entry idx invalid: increment idx and stay in SCAN.
  - Entry idx valid: load the Det* operands from table[idx] and the latched ray, clear the cycle counter, go to ISSUE.
- ISSUE:
  - DetInputValid=1, operands held stable.
  - DetInputValid and DetInputReady both high: clear the counter and go to WAIT.
- WAIT:
  - DetInputValid=0 and operands remain stable.
  - On DetOutputReady, the best-hit update applies when DetIntersects=1 and DetDistance < bestDist (strict, unsigned). It records bestHit=1, bestIdx=idx and bestDist=DetDistance.
  - After that, increment idx and return to SCAN.
  - Ties keep the lower index.
- Timeout: the counter increments in each ISSUE or WAIT cycle. When it reaches TIMEOUT-1 with no handshake (ISSUE) or no strobe (WAIT), set timeout=1 and go to DONE. The best-hit values accumulated so far are kept.
- DONE: ResultValid=1 and the Result* outputs reflect the best registers. On ResultReady, go to IDLE.
- TblWrEn and TblClear outside IDLE are ignored. DetOutputReady outside WAIT is ignored.

## Timing
- Reset (areset=0, asynchronous):
  - State goes to IDLE and all entry valid bits clear.
  - Outputs: ResultValid=0, ResultHit=0, ResultIndex=0, ResultDistance=32'hFFFFFFFF, ResultTimeout=0, DetInputValid=0, all Det* operands 0.
  - RayReady=1 once in IDLE.
- Reset mid-scan aborts with no result; the table must be reloaded.
- Ray accept: on the edge where RayValid and RayReady are both high. RayReady falls in the following cycle.
- SCAN costs one cycle per examined entry, including the terminal idx==NUM_SPHERES check.
- Empty table: ResultValid rises NUM_SPHERES+1 edges after the accept edge.
- A valid entry with detector handshake latency h and strobe latency L (edges from handshake to DetOutputReady) costs 1 (SCAN) + h+1 (ISSUE) + L (WAIT) cycles.
- The first SCAN cycle after a strobe examines idx+1.
- Result* outputs are stable while ResultValid=1. The result is taken on the edge where ResultValid and ResultReady are both high. The next ray can be accepted one cycle later at the earliest.
- Back-to-back rays need no gap beyond the DONE→IDLE cycle.

## Test plan
- Empty table (TblClear), ray accepted → ResultValid after 9 edges (NUM_SPHERES=8), Hit=0, Index=0, Distance=FFFFFFFF, Timeout=0.
- Entries 1, 4 and 6 valid; model returns hit distances 100, 40 and 40 → Hit=1, Index=4, Distance=40. Exactly three DetInputValid handshakes, and Det operands match the table entries.
- Entry 2 only valid; model returns Intersects=0, Distance=5 → Hit=0, Distance=FFFFFFFF.
- Entry 0 valid; model never strobes DetOutputReady → ResultValid with Timeout=1 after 64 WAIT cycles. A later stray strobe in IDLE is ignored.
- ResultReady held low for 10 cycles → Result* stable, RayReady=0, TblWrEn to entry 3 ignored. The next scan does not see entry 3.
- areset pulsed low during WAIT → all outputs at their reset values immediately. A subsequent ray yields the empty-table result.
